// File: rtl/stopwatch_time_counter.sv
// MM:SS BCD stopwatch counter: prescaled one-second roll, ripple-carry live digits,
// and a LIVE/HOLD lap register that freezes the displayed value.
module stopwatch_time_counter #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       enable,
   input  logic       lap,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       holding,
   output logic       sec_tick,
   output logic       wrap
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic {LIVE, HOLD} lap_state_e;

   lap_state_e    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
   logic [15:0]   lap_q, lap_d;
   logic          tick_q, tick_d, wrap_q, wrap_d;
   logic          roll;

   assign roll = enable && (presc_q == PMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LIVE;
         presc_q <= '0;
         so_q    <= '0;
         st_q    <= '0;
         mo_q    <= '0;
         mt_q    <= '0;
         lap_q   <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         so_q    <= so_d;
         st_q    <= st_d;
         mo_q    <= mo_d;
         mt_q    <= mt_d;
         lap_q   <= lap_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      so_d    = so_q;
      st_d    = st_q;
      mo_d    = mo_q;
      mt_d    = mt_q;
      lap_d   = lap_q;
      tick_d  = roll;
      wrap_d  = roll && (so_q == 4'd9) && (st_q == 4'd5) && (mo_q == 4'd9) && (mt_q == 4'd9);

      if (roll)        presc_d = '0;
      else if (enable) presc_d = presc_q + 1'b1;

      if (roll) begin
         if (so_q == 4'd9) begin
            so_d = 4'd0;
            if (st_q == 4'd5) begin
               st_d = 4'd0;
               if (mo_q == 4'd9) begin
                  mo_d = 4'd0;
                  mt_d = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;
               end else begin
                  mo_d = mo_q + 4'd1;
               end
            end else begin
               st_d = st_q + 4'd1;
            end
         end else begin
            so_d = so_q + 4'd1;
         end
      end

      // Capture uses the _q digits, so a lap coincident with roll freezes the pre-increment time.
      if (lap) begin
         case (state_q)
            LIVE: begin
               lap_d   = {mt_q, mo_q, st_q, so_q};
               state_d = HOLD;
            end
            default: state_d = LIVE;
         endcase
      end

      if (clear) begin
         state_d = LIVE;
         presc_d = '0;
         so_d    = '0;
         st_d    = '0;
         mo_d    = '0;
         mt_d    = '0;
         lap_d   = '0;
         tick_d  = 1'b0;
         wrap_d  = 1'b0;
      end
   end

   assign holding  = (state_q == HOLD);
   assign sec_tick = tick_q;
   assign wrap     = wrap_q;
   assign {min_tens, min_ones, sec_tens, sec_ones} = holding ? lap_q : {mt_q, mo_q, st_q, so_q};

endmodule
